// File: rtl/tm1638_key_reader.sv
// TM1638 key-scan reader: sends the read-key command 0x42, releases DIO and
// clocks in four scan bytes, then decodes them into an 8-bit key vector.
module tm1638_key_reader #(
   parameter int unsigned CLK_DIV     = 50,
   parameter int unsigned WAIT_CYCLES = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic [7:0] keys,
   output logic       tm_stb,
   output logic       tm_clk,
   output logic       tm_dio_out,
   output logic       tm_dio_oe,
   input  logic       tm_dio_in
);

   localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam int unsigned BIT_W  = 6;
   localparam int unsigned SHIFT_W = 32;

   localparam logic [7:0]        CMD_READ_KEYS = 8'h42;
   localparam logic [DIV_W-1:0]  DIV_LAST      = DIV_W'(CLK_DIV - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST     = WAIT_W'(WAIT_CYCLES - 1);
   localparam logic [BIT_W-1:0]  CMD_LAST_BIT  = BIT_W'(7);
   localparam logic [BIT_W-1:0]  READ_LAST_BIT = BIT_W'(31);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_WAIT,
      S_READ,
      S_STOP
   } state_t;

   state_t               state_q, state_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic                 phase_q, phase_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [WAIT_W-1:0]    wait_q, wait_d;
   logic [SHIFT_W-1:0]   shift_q, shift_d;
   logic [7:0]           keys_q, keys_d;
   logic                 done_q, done_d;
   logic                 busy_q, busy_d;
   logic                 stb_q, stb_d;
   logic                 clk_q, clk_d;
   logic                 dout_q, dout_d;
   logic                 oe_q, oe_d;

   // State, counters and registered pin/status outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         phase_q <= 1'b0;
         bit_q   <= '0;
         wait_q  <= '0;
         shift_q <= '0;
         keys_q  <= 8'h00;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         stb_q   <= 1'b1;
         clk_q   <= 1'b1;
         dout_q  <= 1'b1;
         oe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
         wait_q  <= wait_d;
         shift_q <= shift_d;
         keys_q  <= keys_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         stb_q   <= stb_d;
         clk_q   <= clk_d;
         dout_q  <= dout_d;
         oe_q    <= oe_d;
      end
   end

   // Next state; pin outputs are derived from the next state so they register in step.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      phase_d = phase_q;
      bit_d   = bit_q;
      wait_d  = wait_q;
      shift_d = shift_q;
      keys_d  = keys_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_CMD;
               div_d   = '0;
               phase_d = 1'b0;
               bit_d   = '0;
            end
         end
         S_CMD, S_READ: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               if (!phase_q) begin
                  // Last low-phase cycle: DIO is captured as tm_clk rises.
                  phase_d = 1'b1;
                  if (state_q == S_READ) begin
                     shift_d = {tm_dio_in, shift_q[SHIFT_W-1:1]};
                  end
               end else begin
                  phase_d = 1'b0;
                  if (state_q == S_CMD && bit_q == CMD_LAST_BIT) begin
                     state_d = S_WAIT;
                     wait_d  = '0;
                  end else if (state_q == S_READ && bit_q == READ_LAST_BIT) begin
                     state_d = S_STOP;
                  end else begin
                     bit_d = bit_q + 1'b1;
                  end
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         S_WAIT: begin
            if (wait_q == WAIT_LAST) begin
               state_d = S_READ;
               div_d   = '0;
               phase_d = 1'b0;
               bit_d   = '0;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_STOP: begin
            if (div_q == DIV_LAST) begin
               state_d = S_IDLE;
               div_d   = '0;
               done_d  = 1'b1;
               for (int i = 0; i < 4; i++) begin
                  keys_d[i]     = shift_q[8*i];
                  keys_d[i + 4] = shift_q[8*i + 4];
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      stb_d  = 1'b1;
      clk_d  = 1'b1;
      dout_d = 1'b1;
      oe_d   = 1'b0;
      busy_d = (state_d != S_IDLE);
      case (state_d)
         S_CMD: begin
            stb_d  = 1'b0;
            clk_d  = phase_d;
            oe_d   = 1'b1;
            dout_d = CMD_READ_KEYS[bit_d[2:0]];
         end
         S_WAIT: stb_d = 1'b0;
         S_READ: begin
            stb_d = 1'b0;
            clk_d = phase_d;
         end
         default: ;
      endcase
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign keys       = keys_q;
   assign tm_stb     = stb_q;
   assign tm_clk     = clk_q;
   assign tm_dio_out = dout_q;
   assign tm_dio_oe  = oe_q;

endmodule

// File: tb/tb_tm1638_key_reader.sv
// Directed bench for tm1638_key_reader: default-parameter instance plus a
// CLK_DIV=1/WAIT_CYCLES=1 instance, each with a small TM1638 DIO model.
module tb_tm1638_key_reader;

   logic clk = 1'b0;
   logic reset;
   logic start, start_s;

   logic busy, done, tm_stb, tm_clk, tm_dio_out, tm_dio_oe;
   logic [7:0] keys;
   logic dio_in = 1'b1;

   logic busy_s, done_s, tm_stb_s, tm_clk_s, tm_dio_out_s, tm_dio_oe_s;
   logic [7:0] keys_s;
   logic dio_in_s = 1'b1;

   int compared = 0;
   int mismatched = 0;

   logic [31:0] dev_data, dev_data_s;
   int          falls = 0, rises = 0, falls_s = 0;
   logic [7:0]  cmd_byte = 8'h00;
   logic        prev_clk = 1'b1, prev_clk_s = 1'b1;

   always #5 clk = ~clk;

   tm1638_key_reader dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .keys(keys),
      .tm_stb(tm_stb), .tm_clk(tm_clk), .tm_dio_out(tm_dio_out), .tm_dio_oe(tm_dio_oe),
      .tm_dio_in(dio_in)
   );

   tm1638_key_reader #(.CLK_DIV(1), .WAIT_CYCLES(1)) dut_s (
      .clk(clk), .reset(reset), .start(start_s), .busy(busy_s), .done(done_s), .keys(keys_s),
      .tm_stb(tm_stb_s), .tm_clk(tm_clk_s), .tm_dio_out(tm_dio_out_s), .tm_dio_oe(tm_dio_oe_s),
      .tm_dio_in(dio_in_s)
   );

   // Device model: records command bits on rising CLK, drives scan bits after each falling CLK.
   always @(negedge clk) begin
      if (tm_stb !== 1'b0) begin
         falls  <= 0;
         rises  <= 0;
         dio_in <= 1'b1;
      end else begin
         if (prev_clk && !tm_clk) begin
            falls <= falls + 1;
            if (falls >= 8 && falls < 40) dio_in <= dev_data[5'(falls - 8)];
         end
         if (!prev_clk && tm_clk && tm_dio_oe) begin
            rises    <= rises + 1;
            cmd_byte <= {tm_dio_out, cmd_byte[7:1]};
         end
      end
      prev_clk <= tm_clk;
   end

   always @(negedge clk) begin
      if (tm_stb_s !== 1'b0) begin
         falls_s  <= 0;
         dio_in_s <= 1'b1;
      end else if (prev_clk_s && !tm_clk_s) begin
         falls_s <= falls_s + 1;
         if (falls_s >= 8 && falls_s < 40) dio_in_s <= dev_data_s[5'(falls_s - 8)];
      end
      prev_clk_s <= tm_clk_s;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Runs one default-parameter read from cycle T+1 until done (or a cycle budget).
   task automatic run_read(input bit poke, input logic [7:0] exp_keys);
      int n = 1;
      int oe_drop = 0;
      int wait_hi = 0;
      int done_n = 0;
      while (done_n == 0 && n < 6000) begin
         start = poke && (n == 1000);
         tick();
         n++;
         if (oe_drop == 0 && !tm_dio_oe) begin
            oe_drop = n;
            chk("cmd_bits", {24'(rises), cmd_byte}, {24'd8, 8'h42});
         end
         if (n > 800 && n <= 900 && tm_clk && !tm_stb && !tm_dio_oe && tm_dio_out) wait_hi++;
         if (n == 901) chk("read_clk_low", 32'(tm_clk), 32'd0);
         if (done) begin
            done_n = n;
            chk("busy_at_done", 32'(busy), 32'd0);
            chk("keys", 32'(keys), 32'(exp_keys));
         end
      end
      start = 1'b0;
      chk("oe_drop", oe_drop, 801);
      chk("wait_clk_high", wait_hi, 100);
      chk("done_time", done_n, 4151);
   endtask

   initial begin
      int n;
      int pulses;
      reset      = 1'b0;
      start      = 1'b1;
      start_s    = 1'b1;
      dev_data   = 32'h0;
      dev_data_s = 32'h0;

      for (int i = 0; i < 5; i++) begin
         tick();
         chk("reset_outs", {tm_stb, tm_clk, tm_dio_out, tm_dio_oe, busy, done, keys},
             {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
         chk("reset_outs_s", {tm_stb_s, tm_clk_s, tm_dio_oe_s, busy_s, done_s, keys_s},
             {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
      end
      reset   = 1'b1;
      start   = 1'b0;
      start_s = 1'b0;
      tick();
      tick();
      chk("idle_after_reset", {tm_stb, busy}, 2'b10);

      // Read 1: keys 0 and 6, with an ignored start during READ.
      dev_data = 32'h0010_0001;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("cmd_stb_fall", {tm_stb, tm_dio_oe, busy}, 3'b011);
      run_read(1'b1, 8'h41);

      // Start in the done cycle is accepted immediately.
      dev_data = 32'hEEEE_EEEE;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("chain_start", {tm_stb, busy, done}, 3'b010);
      run_read(1'b0, 8'h00);

      dev_data = 32'h1111_1111;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("chain_start2", {tm_stb, busy, done}, 3'b010);
      run_read(1'b0, 8'hFF);
      tick();
      chk("done_single", 32'(done), 32'd0);

      // Reset mid-READ clears everything without a done pulse.
      tick();
      dev_data = 32'h0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (n = 1; n < 2000; n++) tick();
      chk("pre_reset", {busy, keys}, {1'b1, 8'hFF});
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("mid_reset", {tm_stb, tm_clk, tm_dio_oe, busy, done, keys},
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
      pulses = 0;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (done || busy) pulses++;
      end
      chk("no_done_after_reset", pulses, 0);

      dev_data = 32'h0010_0001;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("fresh_stb_fall", {tm_stb, busy}, 2'b01);
      run_read(1'b0, 8'h41);

      // Parameter corner: CLK_DIV=1, WAIT_CYCLES=1.
      dev_data_s = 32'h0010_0001;
      start_s = 1'b1;
      tick();
      start_s = 1'b0;
      chk("small_c1", {tm_stb_s, tm_clk_s}, 2'b00);
      tick();
      chk("small_c2", {tm_stb_s, tm_clk_s}, 2'b01);
      tick();
      chk("small_c3", {tm_stb_s, tm_clk_s}, 2'b00);
      n = 3;
      while (!done_s && n < 500) begin
         tick();
         n++;
      end
      chk("small_done_time", n, 83);
      chk("small_keys", {busy_s, keys_s}, {1'b0, 8'h41});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
